microsequencer: RTL and testbench
=================================

Name: microsequencer

Overview:
- Next-state engine of the microprogrammed control unit.
- Consumes the registered microinstruction fields from the control pipeline register: NS_select, Inv, Sts_select, Pl7 and CurrentState.
- Combines them with status conditions and the instruction-decoder address, then registers the next control-store address.
- That address drives the microstore ROM, whose outputs feed the control pipeline register. This closes the microcode loop.

Parameters:
AW, 8, width of control-store address / state
DEPTH, 4, entries in the microcode return-address stack (power of 2, 2..16)
TRAP_VEC, 8'd2, state entered on trap request
RESET_VEC, 8'd0, state after reset

Ports:
Clk  input  1  rising-edge clock
Reset_n  input  1  asynchronous active-low reset
NS_select  input  3  next-state operation, from pipeline register
Inv  input  1  invert selected condition
Sts_select  input  2  condition selector
Cond_in  input  4  status conditions: [0] MOC, [1] branch-condition-tester true, [2] trap-enable, [3] spare
Pl7  input  AW  microinstruction jump target
CurrentState  input  AW  state of microinstruction now in the pipeline register
Decode_addr  input  AW  entry address from instruction encoder
Trap_req  input  1  synchronous trap request
Stall  input  1  freeze sequencer
State  output  AW  registered control-store address
Stack_err  output  1  sticky overflow/underflow flag
Sp  output  log2(DEPTH)+1  stack occupancy count

Behaviour:
- Reset (Reset_n=0, asynchronous):
  - State=RESET_VEC, Sp=0, Stack_err=0.
  - Stack contents are don't-care.
  - Reset asserted mid-operation aborts any pending push or pop.
- cond = Cond_in[Sts_select] XOR Inv.
- inc = CurrentState+1, mod 2^AW (255 -> 0 for AW=8, no flag).
- Priority on each posedge: Trap_req > Stall > NS_select.
- Trap_req=1: State<=TRAP_VEC, Sp<=0. Stack_err is unchanged.
- Stall=1 (no trap): State, Sp, stack and Stack_err all hold.
- NS_select decode (one-cycle latency, State valid the cycle after inputs):
  - 000 INC: State<=inc
  - 001 JMP: State<=Pl7
  - 010 DEC: State<=Decode_addr
  - 011 CJMP: State<= cond ? Pl7 : inc
  - 100 CDEC: State<= cond ? Pl7 : Decode_addr
  - 101 CALL: push inc, State<=Pl7
  - 110 RET: pop, State<=top of stack
  - 111 CWAIT: State<= cond ? inc : CurrentState (e.g. wait for MOC)
- Stack is LIFO, Sp counts entries 0..DEPTH.
  - Push writes entry[Sp], then Sp+1.
  - Pop reads entry[Sp-1], then Sp-1.
- CALL with Sp==DEPTH (full):
  - The push is dropped and Sp holds.
  - Stack_err<=1.
  - State still goes to Pl7.
- RET with Sp==0 (empty):
  - State<=RESET_VEC and Sp holds.
  - Stack_err<=1.
- Stack_err is cleared only by reset.
- State uses CurrentState, not its own output. The pipeline register provides the one-cycle-delayed copy. Both values equal each other in the bubble-free steady state.
- Pure registered outputs: no combinational path from inputs to State, Sp or Stack_err.

Test Plan:
- Reset release: Reset_n low for 3 cycles then high; NS=000, CurrentState=0 -> State 0, then 1 on the next edge. Sp=0, Stack_err=0.
- Conditional and wrap:
  - CurrentState=8'hFF, NS=000 -> State=8'h00.
  - NS=011, Pl7=8'h40, Sts_select=1, Cond_in=4'b0010, Inv=0 -> State=8'h40.
  - Same with Inv=1 -> State=CurrentState+1.
- Wait loop: NS=111, Sts_select=0, MOC=0 for 3 cycles -> State stays at CurrentState=8'h10. MOC=1 -> State=8'h11.
- Call/return nesting:
  - CALL from 8'h20 to 8'h50, then CALL from 8'h50 to 8'h60 -> Sp=2.
  - RET -> State=8'h51, Sp=1.
  - RET -> State=8'h21, Sp=0, Stack_err=0.
- Stack faults:
  - 5 CALLs (DEPTH=4) -> Sp=4, Stack_err=1. The 5th target is still taken.
  - 4 RETs pop in LIFO order.
  - A 5th RET -> State=RESET_VEC.
- Trap and stall priority:
  - Stall=1 with NS=001, Pl7=8'h33 -> State holds.
  - Trap_req=1 with Stall=1 and Sp=2 -> State=TRAP_VEC, Sp=0.

Source files
------------

// File: rtl/microsequencer.sv
// Next-address engine of the microprogrammed control unit: selects the next
// control-store address from the pipeline fields, status conditions and a return stack.
module microsequencer #(
    parameter int              AW        = 8,
    parameter int              DEPTH     = 4,
    parameter logic [AW-1:0]   TRAP_VEC  = AW'(2),
    parameter logic [AW-1:0]   RESET_VEC = AW'(0)
) (
    input  logic                       Clk,
    input  logic                       Reset_n,
    input  logic [2:0]                 NS_select,
    input  logic                       Inv,
    input  logic [1:0]                 Sts_select,
    input  logic [3:0]                 Cond_in,
    input  logic [AW-1:0]              Pl7,
    input  logic [AW-1:0]              CurrentState,
    input  logic [AW-1:0]              Decode_addr,
    input  logic                       Trap_req,
    input  logic                       Stall,
    output logic [AW-1:0]              State,
    output logic                       Stack_err,
    output logic [$clog2(DEPTH):0]     Sp
);

    localparam int PW  = $clog2(DEPTH);
    localparam int SPW = PW + 1;

    typedef enum logic [2:0] {
        NS_INC   = 3'b000,
        NS_JMP   = 3'b001,
        NS_DEC   = 3'b010,
        NS_CJMP  = 3'b011,
        NS_CDEC  = 3'b100,
        NS_CALL  = 3'b101,
        NS_RET   = 3'b110,
        NS_CWAIT = 3'b111
    } ns_op_t;

    logic [AW-1:0]  state_reg, state_next;
    logic [SPW-1:0] sp_reg, sp_next;
    logic           err_reg, err_next;
    logic           push_en;

    logic [AW-1:0]  stack_mem [DEPTH];

    logic           cond;
    logic [AW-1:0]  inc;
    logic [SPW-1:0] sp_dec;
    logic [AW-1:0]  stack_top;
    logic           stack_full;
    logic           stack_empty;
    ns_op_t         op;

    assign cond        = Cond_in[Sts_select] ^ Inv;
    assign inc         = CurrentState + AW'(1);
    assign sp_dec      = sp_reg - SPW'(1);
    assign stack_top   = stack_mem[sp_dec[PW-1:0]];
    assign stack_full  = (sp_reg == SPW'(DEPTH));
    assign stack_empty = (sp_reg == '0);
    assign op          = ns_op_t'(NS_select);

    always_comb begin
        state_next = state_reg;
        sp_next    = sp_reg;
        err_next   = err_reg;
        push_en    = 1'b0;

        if (Trap_req) begin
            state_next = TRAP_VEC;
            sp_next    = '0;
        end else if (!Stall) begin
            case (op)
                NS_INC:   state_next = inc;
                NS_JMP:   state_next = Pl7;
                NS_DEC:   state_next = Decode_addr;
                NS_CJMP:  state_next = cond ? Pl7 : inc;
                NS_CDEC:  state_next = cond ? Pl7 : Decode_addr;
                NS_CALL: begin
                    // The jump is taken even when the return address cannot be saved.
                    state_next = Pl7;
                    if (stack_full) begin
                        err_next = 1'b1;
                    end else begin
                        push_en = 1'b1;
                        sp_next = sp_reg + SPW'(1);
                    end
                end
                NS_RET: begin
                    if (stack_empty) begin
                        state_next = RESET_VEC;
                        err_next   = 1'b1;
                    end else begin
                        state_next = stack_top;
                        sp_next    = sp_dec;
                    end
                end
                NS_CWAIT: state_next = cond ? inc : CurrentState;
                default:  state_next = state_reg;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_reg <= RESET_VEC;
            sp_reg    <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            sp_reg    <= sp_next;
            err_reg   <= err_next;
        end
    end

    // Stack contents need no reset; gating on Reset_n drops a push racing a reset.
    always_ff @(posedge Clk) begin
        if (push_en && Reset_n) begin
            stack_mem[sp_reg[PW-1:0]] <= inc;
        end
    end

    assign State     = state_reg;
    assign Sp        = sp_reg;
    assign Stack_err = err_reg;

endmodule

// File: tb/tb_microsequencer.sv
// Scoreboard bench for microsequencer: a behavioural model queues expected
// State/Sp/Stack_err per cycle, compared one cycle after each stimulus.
module tb_microsequencer;

    logic       Clk;
    logic       Reset_n;
    logic [2:0] NS_select;
    logic       Inv;
    logic [1:0] Sts_select;
    logic [3:0] Cond_in;
    logic [7:0] Pl7;
    logic [7:0] CurrentState;
    logic [7:0] Decode_addr;
    logic       Trap_req;
    logic       Stall;
    logic [7:0] State;
    logic       Stack_err;
    logic [2:0] Sp;

    microsequencer #(
        .AW(8), .DEPTH(4), .TRAP_VEC(8'd2), .RESET_VEC(8'd0)
    ) dut (
        .Clk(Clk), .Reset_n(Reset_n), .NS_select(NS_select), .Inv(Inv),
        .Sts_select(Sts_select), .Cond_in(Cond_in), .Pl7(Pl7),
        .CurrentState(CurrentState), .Decode_addr(Decode_addr),
        .Trap_req(Trap_req), .Stall(Stall), .State(State),
        .Stack_err(Stack_err), .Sp(Sp)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;

    logic [11:0] exp_q [$];
    logic [7:0]  m_stack [$];
    logic [7:0]  m_state;
    logic        m_err;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    task automatic model_reset();
        m_state = 8'd0;
        m_err   = 1'b0;
        m_stack.delete();
    endtask

    // Behavioural next-state from the operation table; stack held as a queue.
    task automatic model_step(input logic [2:0] ns, input logic inv, input logic [1:0] sts,
                              input logic [3:0] ci, input logic [7:0] pl7, input logic [7:0] cur,
                              input logic [7:0] dec, input logic trap, input logic stall);
        logic       c;
        logic [7:0] nx;
        c  = ci[sts] ^ inv;
        nx = cur + 8'd1;
        if (trap) begin
            m_state = 8'd2;
            m_stack.delete();
        end else if (!stall) begin
            case (ns)
                3'd0: m_state = nx;
                3'd1: m_state = pl7;
                3'd2: m_state = dec;
                3'd3: m_state = c ? pl7 : nx;
                3'd4: m_state = c ? pl7 : dec;
                3'd5: begin
                    if (m_stack.size() >= 4) m_err = 1'b1;
                    else m_stack.push_back(nx);
                    m_state = pl7;
                end
                3'd6: begin
                    if (m_stack.size() == 0) begin
                        m_err   = 1'b1;
                        m_state = 8'd0;
                    end else begin
                        m_state = m_stack.pop_back();
                    end
                end
                default: m_state = c ? nx : cur;
            endcase
        end
        exp_q.push_back({m_state, 3'(m_stack.size()), m_err});
    endtask

    task automatic step(input string tag, input logic [2:0] ns, input logic inv,
                        input logic [1:0] sts, input logic [3:0] ci, input logic [7:0] pl7,
                        input logic [7:0] cur, input logic [7:0] dec,
                        input logic trap, input logic stall);
        logic [11:0] e;
        NS_select    = ns;
        Inv          = inv;
        Sts_select   = sts;
        Cond_in      = ci;
        Pl7          = pl7;
        CurrentState = cur;
        Decode_addr  = dec;
        Trap_req     = trap;
        Stall        = stall;
        model_step(ns, inv, sts, ci, pl7, cur, dec, trap, stall);
        @(posedge Clk);
        #1;
        e = exp_q.pop_front();
        chk({tag, ".state"}, 32'(State),     32'(e[11:4]));
        chk({tag, ".sp"},    32'(Sp),        32'(e[3:1]));
        chk({tag, ".err"},   32'(Stack_err), 32'(e[0]));
    endtask

    initial begin
        Reset_n = 1'b1;
        NS_select = 3'd0; Inv = 1'b0; Sts_select = 2'd0; Cond_in = 4'd0;
        Pl7 = 8'd0; CurrentState = 8'd0; Decode_addr = 8'd0;
        Trap_req = 1'b0; Stall = 1'b0;
        #2 Reset_n = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        chk("reset.state", 32'(State), 32'h0);
        chk("reset.sp",    32'(Sp),    32'h0);
        chk("reset.err",   32'(Stack_err), 32'h0);
        Reset_n = 1'b1;
        model_reset();

        // Reset release and increment / wrap.
        step("inc0",   3'd0, 0, 2'd0, 4'b0000, 8'h00, 8'h00, 8'h00, 0, 0);
        chk("inc0.const", 32'(State), 32'h01);
        step("wrap",   3'd0, 0, 2'd0, 4'b0000, 8'h00, 8'hFF, 8'h00, 0, 0);
        chk("wrap.const", 32'(State), 32'h00);

        // Conditional jump, with and without inversion.
        step("cjmp_t", 3'd3, 0, 2'd1, 4'b0010, 8'h40, 8'h30, 8'h00, 0, 0);
        chk("cjmp_t.const", 32'(State), 32'h40);
        step("cjmp_i", 3'd3, 1, 2'd1, 4'b0010, 8'h40, 8'h40, 8'h00, 0, 0);
        chk("cjmp_i.const", 32'(State), 32'h41);

        // Wait loop on MOC.
        for (int i = 0; i < 3; i++)
            step("cwait0", 3'd7, 0, 2'd0, 4'b0000, 8'h00, 8'h10, 8'h00, 0, 0);
        chk("cwait0.const", 32'(State), 32'h10);
        step("cwait1", 3'd7, 0, 2'd0, 4'b0001, 8'h00, 8'h10, 8'h00, 0, 0);
        chk("cwait1.const", 32'(State), 32'h11);

        // Decode and conditional decode.
        step("dec",    3'd2, 0, 2'd0, 4'b0000, 8'h77, 8'h11, 8'h9A, 0, 0);
        step("cdec_f", 3'd4, 0, 2'd2, 4'b0000, 8'h77, 8'h9A, 8'hC3, 0, 0);
        step("cdec_t", 3'd4, 0, 2'd2, 4'b0100, 8'h77, 8'hC3, 8'hC3, 0, 0);
        step("jmp",    3'd1, 0, 2'd0, 4'b0000, 8'h20, 8'h77, 8'h00, 0, 0);

        // Nested call / return.
        step("call1",  3'd5, 0, 2'd0, 4'b0000, 8'h50, 8'h20, 8'h00, 0, 0);
        step("call2",  3'd5, 0, 2'd0, 4'b0000, 8'h60, 8'h50, 8'h00, 0, 0);
        chk("call2.sp", 32'(Sp), 32'd2);
        step("ret1",   3'd6, 0, 2'd0, 4'b0000, 8'h00, 8'h60, 8'h00, 0, 0);
        chk("ret1.const", 32'(State), 32'h51);
        step("ret2",   3'd6, 0, 2'd0, 4'b0000, 8'h00, 8'h51, 8'h00, 0, 0);
        chk("ret2.const", 32'(State), 32'h21);
        chk("ret2.err",   32'(Stack_err), 32'h0);

        // Overflow: fifth call dropped but target taken.
        for (int i = 0; i < 5; i++)
            step("ovf", 3'd5, 0, 2'd0, 4'b0000, 8'h80 + 8'(i), 8'h70 + 8'(i), 8'h00, 0, 0);
        chk("ovf.sp",    32'(Sp),        32'd4);
        chk("ovf.err",   32'(Stack_err), 32'h1);
        chk("ovf.state", 32'(State),     32'h84);
        for (int i = 0; i < 4; i++) begin
            step("lifo", 3'd6, 0, 2'd0, 4'b0000, 8'h00, 8'h84, 8'h00, 0, 0);
            chk("lifo.const", 32'(State), 32'(8'h74 - 8'(i)));
        end
        step("unf",    3'd6, 0, 2'd0, 4'b0000, 8'h00, 8'h71, 8'h00, 0, 0);
        chk("unf.const", 32'(State), 32'h00);

        // Stall and trap priority.
        step("pre1",   3'd5, 0, 2'd0, 4'b0000, 8'h90, 8'h00, 8'h00, 0, 0);
        step("pre2",   3'd5, 0, 2'd0, 4'b0000, 8'hA0, 8'h90, 8'h00, 0, 0);
        step("stall",  3'd1, 0, 2'd0, 4'b0000, 8'h33, 8'hA0, 8'h00, 0, 1);
        chk("stall.const", 32'(State), 32'hA0);
        step("trap",   3'd1, 0, 2'd0, 4'b0000, 8'h33, 8'hA0, 8'h00, 1, 1);
        chk("trap.const", 32'(State), 32'h02);
        chk("trap.sp",    32'(Sp),    32'h0);

        // Reset clears sticky error; then a random mix against the model.
        Reset_n = 1'b0;
        #1;
        chk("rst2.err", 32'(Stack_err), 32'h0);
        Reset_n = 1'b1;
        model_reset();
        for (int i = 0; i < 60; i++) begin
            step("rand", 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
                 8'($urandom_range(0, 255)), m_state, 8'($urandom_range(0, 255)),
                 ($urandom_range(0, 19) == 0), ($urandom_range(0, 7) == 0));
        end

        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard leftover=%0d expected=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
